menu_select_ctrl: RTL and testbench

Parametrised menu controller for the VGA front end: holds an N-item vertical menu, moves a cursor on debounced up/down pulses, reports the chosen item to game control through a valid/ready handshake, and generates registered per-pixel draw strobes for item frames, the highlighted item and a blinking cursor marker. It sits between the key-input conditioning logic and the pixel mux, replacing the fixed four-box menu overlay with a configurable one that owns its own navigation state.

---
 rtl/menu_select_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_menu_select_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/menu_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : menu_select_ctrl
// Purpose  : N-item vertical menu with cursor navigation, valid/ready item
//            selection and registered per-pixel draw strobes.
// Revision : 1.0  initial release
// ============================================================================
module menu_select_ctrl #(
    parameter int N_ITEMS      = 4,
    parameter int WRAP         = 1,
    parameter int X0           = 80,
    parameter int Y0           = 200,
    parameter int PITCH        = 80,
    parameter int BOX_W        = 360,
    parameter int BOX_H        = 50,
    parameter int BORDER       = 3,
    parameter int CUR_X        = 450,
    parameter int CUR_SZ       = 20,
    parameter int BLINK_FRAMES = 16,
    parameter int CW           = $clog2(N_ITEMS)
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    input  logic          en,
    input  logic          up,
    input  logic          down,
    input  logic          select,
    input  logic          frame_tick,
    input  logic [9:0]    Hpos,
    input  logic [9:0]    Vpos,
    output logic [CW-1:0] cursor,
    output logic          sel_valid,
    output logic [CW-1:0] sel_item,
    input  logic          sel_ready,
    output logic          draw_box,
    output logic          draw_hl,
    output logic          draw_cur
);

    typedef enum logic [1:0] {
        S_HIDDEN  = 2'd0,
        S_BROWSE  = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    localparam int            NSLOT        = 1 << CW;
    localparam int            BW           = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] c_last       = CW'(N_ITEMS - 1);
    localparam logic [BW-1:0] c_blink_last = BW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
    localparam logic [10:0]   c_x_box0     = 11'(X0);
    localparam logic [10:0]   c_x_box1     = 11'(X0 + BOX_W);
    localparam logic [10:0]   c_x_in0      = 11'(X0 + BORDER);
    localparam logic [10:0]   c_x_in1      = 11'(X0 + BOX_W - BORDER);
    localparam logic [10:0]   c_x_cur0     = 11'(CUR_X);
    localparam logic [10:0]   c_x_cur1     = 11'(CUR_X + CUR_SZ);

    state_t        state_q, state_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic          sel_valid_q, sel_valid_d;
    logic [CW-1:0] sel_item_q, sel_item_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic          draw_box_q, draw_box_d;
    logic          draw_hl_q, draw_hl_d;
    logic          draw_cur_q, draw_cur_d;
    logic          blink_clr;

    logic [10:0]      w_hx, w_vy;
    logic             w_in_x_box, w_in_x_in, w_in_x_cur;
    logic [NSLOT-1:0] w_item_box, w_item_inner, w_item_cur_y;
    logic             w_visible;

    // Navigation, selection handshake and blink phase
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        sel_valid_d = sel_valid_q;
        sel_item_d  = sel_item_q;
        blink_clr   = 1'b0;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;

        case (state_q)
            S_HIDDEN: begin
                if (en) begin
                    state_d   = S_BROWSE;
                    blink_clr = 1'b1;
                end
            end
            S_BROWSE: begin
                if (!en) begin
                    state_d = S_HIDDEN;
                end else if (select) begin
                    sel_valid_d = 1'b1;
                    sel_item_d  = cursor_q;
                    state_d     = S_PENDING;
                end else if (up && !down) begin
                    if (cursor_q != '0) begin
                        cursor_d  = cursor_q - CW'(1);
                        blink_clr = 1'b1;
                    end else if (WRAP != 0) begin
                        cursor_d  = c_last;
                        blink_clr = 1'b1;
                    end
                end else if (down && !up) begin
                    if (cursor_q != c_last) begin
                        cursor_d  = cursor_q + CW'(1);
                        blink_clr = 1'b1;
                    end else if (WRAP != 0) begin
                        cursor_d  = '0;
                        blink_clr = 1'b1;
                    end
                end
            end
            S_PENDING: begin
                if (sel_valid_q && sel_ready) begin
                    sel_valid_d = 1'b0;
                    if (en) begin
                        state_d   = S_BROWSE;
                        blink_clr = 1'b1;
                    end else begin
                        state_d = S_HIDDEN;
                    end
                end
            end
            default: state_d = S_HIDDEN;
        endcase

        // A cursor move or (re)entry into browsing restarts the blink with the marker on
        if (blink_clr) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_tick && (state_q != S_HIDDEN) && (BLINK_FRAMES != 0)) begin
            if (blink_cnt_q == c_blink_last) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    assign w_hx       = {1'b0, Hpos};
    assign w_vy       = {1'b0, Vpos};
    assign w_in_x_box = (w_hx >= c_x_box0) && (w_hx < c_x_box1);
    assign w_in_x_in  = (w_hx >= c_x_in0)  && (w_hx < c_x_in1);
    assign w_in_x_cur = (w_hx >= c_x_cur0) && (w_hx < c_x_cur1);

    // Unused slots above N_ITEMS are tied off so the cursor can index directly
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_item
            if (gi < N_ITEMS) begin : g_real
                localparam logic [10:0] c_top  = 11'(Y0 + gi * PITCH);
                localparam logic [10:0] c_bot  = 11'(Y0 + gi * PITCH + BOX_H);
                localparam logic [10:0] c_itop = 11'(Y0 + gi * PITCH + BORDER);
                localparam logic [10:0] c_ibot = 11'(Y0 + gi * PITCH + BOX_H - BORDER);
                localparam logic [10:0] c_ctop = 11'(Y0 + gi * PITCH + (BOX_H - CUR_SZ) / 2);
                localparam logic [10:0] c_cbot = 11'(Y0 + gi * PITCH + (BOX_H - CUR_SZ) / 2 + CUR_SZ);
                assign w_item_box[gi]   = w_in_x_box && (w_vy >= c_top)  && (w_vy < c_bot);
                assign w_item_inner[gi] = w_in_x_in  && (w_vy >= c_itop) && (w_vy < c_ibot);
                assign w_item_cur_y[gi] = (w_vy >= c_ctop) && (w_vy < c_cbot);
            end else begin : g_pad
                assign w_item_box[gi]   = 1'b0;
                assign w_item_inner[gi] = 1'b0;
                assign w_item_cur_y[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_visible = (state_q != S_HIDDEN) && en;

    always_comb begin
        draw_box_d = w_visible && (|(w_item_box & ~w_item_inner));
        draw_hl_d  = w_visible && w_item_inner[cursor_q];
        draw_cur_d = w_visible && w_in_x_cur && w_item_cur_y[cursor_q] &&
                     (blink_on_q || (BLINK_FRAMES == 0));
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HIDDEN;
            cursor_q    <= '0;
            sel_valid_q <= 1'b0;
            sel_item_q  <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            draw_box_q  <= 1'b0;
            draw_hl_q   <= 1'b0;
            draw_cur_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            sel_valid_q <= sel_valid_d;
            sel_item_q  <= sel_item_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            draw_box_q  <= draw_box_d;
            draw_hl_q   <= draw_hl_d;
            draw_cur_q  <= draw_cur_d;
        end
    end

    assign cursor    = cursor_q;
    assign sel_valid = sel_valid_q;
    assign sel_item  = sel_item_q;
    assign draw_box  = draw_box_q;
    assign draw_hl   = draw_hl_q;
    assign draw_cur  = draw_cur_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_select_ctrl
// Purpose  : Self-checking bench for menu_select_ctrl (wrapping and saturating
//            instances driven in parallel against a behavioural model).
// Revision : 1.0  initial release
// ============================================================================
module tb_menu_select_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b0, down = 1'b0, sel = 1'b0, ready = 1'b0, tick = 1'b0;
    logic [9:0] hpos = '0, vpos = '0;

    logic [1:0] cur_o [2];
    logic       sv_o  [2];
    logic [1:0] si_o  [2];
    logic       box_o [2];
    logic       hl_o  [2];
    logic       dc_o  [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #10 clk = ~clk;

    menu_select_ctrl #(.N_ITEMS(4), .WRAP(1), .BLINK_FRAMES(2)) dut_w (
        .CLOCK_50(clk), .rst_n(rst_n), .en(en), .up(up), .down(down), .select(sel),
        .frame_tick(tick), .Hpos(hpos), .Vpos(vpos), .cursor(cur_o[0]),
        .sel_valid(sv_o[0]), .sel_item(si_o[0]), .sel_ready(ready),
        .draw_box(box_o[0]), .draw_hl(hl_o[0]), .draw_cur(dc_o[0]));

    menu_select_ctrl #(.N_ITEMS(4), .WRAP(0), .BLINK_FRAMES(3)) dut_s (
        .CLOCK_50(clk), .rst_n(rst_n), .en(en), .up(up), .down(down), .select(sel),
        .frame_tick(tick), .Hpos(hpos), .Vpos(vpos), .cursor(cur_o[1]),
        .sel_valid(sv_o[1]), .sel_item(si_o[1]), .sel_ready(ready),
        .draw_box(box_o[1]), .draw_hl(hl_o[1]), .draw_cur(dc_o[1]));

    // Reference model: mode 0 hidden, 1 browsing, 2 waiting for acceptance
    int m_mode[2], m_cur[2], m_sv[2], m_si[2], m_cnt[2], m_on[2];
    int e_box[2], e_hl[2], e_cur[2];
    int m_wrap[2] = '{1, 0};
    int m_bf[2]   = '{2, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_cur[k] = 0; m_sv[k] = 0; m_si[k] = 0;
            m_cnt[k] = 0; m_on[k] = 1; e_box[k] = 0; e_hl[k] = 0; e_cur[k] = 0;
        end
    endtask

    task automatic model_next(input int k);
        int h, v, idx, off, cy, old_mode;
        bit inbox, inner, vis, restart;
        h = int'(hpos); v = int'(vpos);
        inbox = 0; inner = 0; idx = -1; off = 0;
        if (v >= 200) begin
            idx = (v - 200) / 80;
            off = (v - 200) % 80;
            if (idx < 4 && off < 50 && h >= 80 && h < 440) begin
                inbox = 1;
                inner = (h >= 83 && h < 437 && off >= 3 && off < 47);
            end
        end
        vis = (m_mode[k] != 0) && en;
        cy  = 200 + m_cur[k] * 80 + 15;
        e_box[k] = int'(vis && inbox && !inner);
        e_hl[k]  = int'(vis && inner && idx == m_cur[k]);
        e_cur[k] = int'(vis && h >= 450 && h < 470 && v >= cy && v < cy + 20 && m_on[k] != 0);

        old_mode = m_mode[k];
        restart  = 0;
        if (m_mode[k] == 0) begin
            if (en) begin m_mode[k] = 1; restart = 1; end
        end else if (m_mode[k] == 1) begin
            if (!en) m_mode[k] = 0;
            else if (sel) begin m_sv[k] = 1; m_si[k] = m_cur[k]; m_mode[k] = 2; end
            else if (up && !down) begin
                if (m_cur[k] > 0) begin m_cur[k]--; restart = 1; end
                else if (m_wrap[k] != 0) begin m_cur[k] = 3; restart = 1; end
            end else if (down && !up) begin
                if (m_cur[k] < 3) begin m_cur[k]++; restart = 1; end
                else if (m_wrap[k] != 0) begin m_cur[k] = 0; restart = 1; end
            end
        end else begin
            if (ready) begin
                m_sv[k] = 0;
                m_mode[k] = en ? 1 : 0;
                restart = en;
            end
        end

        if (restart) begin
            m_cnt[k] = 0; m_on[k] = 1;
        end else if (tick && old_mode != 0 && m_bf[k] != 0) begin
            m_cnt[k]++;
            if (m_cnt[k] == m_bf[k]) begin m_cnt[k] = 0; m_on[k] = 1 - m_on[k]; end
        end
    endtask

    task automatic step(input bit e, u, d, s, r, t, input int h, input int v);
        en = e; up = u; down = d; sel = s; ready = r; tick = t;
        hpos = 10'(h); vpos = 10'(v);
        model_next(0);
        model_next(1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cursor[%0d]", k),   32'(cur_o[k]), m_cur[k]);
            chk($sformatf("sel_valid[%0d]", k), 32'(sv_o[k]), m_sv[k]);
            chk($sformatf("sel_item[%0d]", k), 32'(si_o[k]),  m_si[k]);
            chk($sformatf("draw_box[%0d]", k), 32'(box_o[k]), e_box[k]);
            chk($sformatf("draw_hl[%0d]", k),  32'(hl_o[k]),  e_hl[k]);
            chk($sformatf("draw_cur[%0d]", k), 32'(dc_o[k]),  e_cur[k]);
        end
    endtask

    initial begin
        model_reset();
        #25;
        for (int k = 0; k < 2; k++) begin
            chk("reset_cursor", 32'(cur_o[k]), 0);
            chk("reset_sel_valid", 32'(sv_o[k]), 0);
            chk("reset_draw", 32'({box_o[k], hl_o[k], dc_o[k]}), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Wrapping navigation
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);  chk("nav_down1", 32'(cur_o[0]), 1);
        step(1, 0, 1, 0, 0, 0, 0, 0);  chk("nav_down2", 32'(cur_o[0]), 2);
        step(1, 0, 1, 0, 0, 0, 0, 0);  chk("nav_down3", 32'(cur_o[0]), 3);
        step(1, 0, 1, 0, 0, 0, 0, 0);  chk("wrap_down", 32'(cur_o[0]), 0);
                                       chk("sat_down",  32'(cur_o[1]), 3);
        step(1, 1, 0, 0, 0, 0, 0, 0);  chk("wrap_up",   32'(cur_o[0]), 3);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);  chk("sat_up", 32'(cur_o[1]), 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);  chk("up_down_hold", 32'(cur_o[1]), 0);

        // Pending selection holds through navigation until accepted
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, i[0], ~i[0], 1, 0, 0, 0, 0);
        chk("pend_valid", 32'(sv_o[1]), 1);
        chk("pend_item",  32'(si_o[1]), 2);
        step(1, 0, 0, 0, 1, 0, 0, 0);  chk("accept_drop", 32'(sv_o[1]), 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);  chk("reselect", 32'(sv_o[1]), 1);
        step(1, 0, 0, 0, 1, 0, 0, 0);

        // Geometry at cursor 1
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 81, 281);   chk("geo_frame", 32'(box_o[1]), 1);
        step(1, 0, 0, 0, 0, 0, 200, 300);  chk("geo_hl", 32'(hl_o[1]), 1);
        step(1, 0, 0, 0, 0, 0, 200, 220);  chk("geo_other", 32'({box_o[1], hl_o[1]}), 0);

        // Blink on the cursor marker
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 455, 295);
        step(1, 0, 1, 0, 0, 1, 455, 295);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, i[0], 455, 375);

        // Hidden: no drawing, cursor kept
        step(0, 0, 0, 0, 0, 0, 455, 375);
        step(0, 0, 1, 0, 0, 0, 200, 380);  chk("hidden_draw", 32'({box_o[0], hl_o[0], dc_o[0]}), 0);

        for (int i = 0; i < 3000; i++)
            step(($urandom % 16) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                 ($urandom % 10) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
                 int'($urandom_range(480, 70)), int'($urandom_range(560, 190)));

        // Asynchronous reset while a selection is pending
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);  chk("pre_reset_valid", 32'(sv_o[0]), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk("async_sel_valid", 32'(sv_o[k]), 0);
            chk("async_cursor", 32'(cur_o[k]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
